spi_master: RTL and testbench

- SPI master that drives the on-chip SPI slave/RAM subsystem from a parallel host interface.
- Each host request becomes one 10-bit command frame: {cmd[1:0], wdata[7:0]}, sent MSB first on MOSI.
- A read-data frame (cmd=2'b11) is followed by an 8-bit response sampled from MISO.
- Serial timing is one bit per clk cycle; the slave runs on the same clk, so there is no separate SCLK.

---
 rtl/spi_master_if.sv | 21 ++
 rtl/spi_master.sv | 122 ++++++++++++
 tb/tb_spi_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// spi_master_if: host request/response signals and serial lines of spi_master
interface spi_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  modport master (
    input  start, cmd, wdata, MISO,
    output ready, done, rdata, rdata_valid, SS_n, MOSI
  );
  modport slave (
    output start, cmd, wdata, MISO,
    input  ready, done, rdata, rdata_valid, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: host-to-SPI framer, 10-bit command frame plus 8-bit response for read-data.
// SPI_MASTER_AUTO_RD_EN: cmd=10 automatically chains a {11,8'h00} read-data frame.
module spi_master #(
  parameter int TURN_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input logic clk,
  input logic rst,
  spi_master_if.master bus
);
  localparam int CW = $clog2(TURN_CYCLES + GAP_CYCLES + 10);
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT_OUT, TURN, SHIFT_IN, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0] sreg, sreg_n;
  logic [7:0] shreg, shreg_n, rdata, rdata_n;
  logic rd, rd_n, chain, chain_n;
  logic ss_n, ss_n_n, mosi, mosi_n, ready, ready_n, done, done_n, valid, valid_n;
  logic last;
  assign last = cnt == '0;
  assign bus.SS_n = ss_n;
  assign bus.MOSI = mosi;
  assign bus.ready = ready;
  assign bus.done = done;
  assign bus.rdata = rdata;
  assign bus.rdata_valid = valid;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sreg_n = sreg;
    shreg_n = shreg;
    rdata_n = rdata;
    rd_n = rd;
    chain_n = chain;
    ss_n_n = ss_n;
    mosi_n = mosi;
    ready_n = ready;
    done_n = 1'b0;
    valid_n = 1'b0;
    unique case (state)
      IDLE: if (bus.start) begin
        sreg_n = {bus.cmd, bus.wdata};
        rd_n = bus.cmd == 2'b11;
        ready_n = 1'b0;
        state_n = LEAD;
`ifdef SPI_MASTER_AUTO_RD_EN
        chain_n = bus.cmd == 2'b10;
`endif
      end
      LEAD: begin
        ss_n_n = 1'b0;
        mosi_n = sreg[9];
        cnt_n = CW'(9);
        state_n = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        mosi_n = sreg[9];
        sreg_n = {sreg[8:0], 1'b0};
        cnt_n = last ? (rd ? CW'(TURN_CYCLES - 1) : '0) : cnt - 1'b1;
        state_n = last ? (rd ? TURN : GAP) : SHIFT_OUT;
      end
      TURN: begin
        mosi_n = 1'b0;
        cnt_n = last ? CW'(7) : cnt - 1'b1;
        state_n = last ? SHIFT_IN : TURN;
      end
      SHIFT_IN: begin
        shreg_n = {shreg[6:0], bus.MISO};
        cnt_n = last ? '0 : cnt - 1'b1;
        state_n = last ? GAP : SHIFT_IN;
      end
      GAP: begin
        cnt_n = cnt + 1'b1;
        if (last) begin
          ss_n_n = 1'b1;
          mosi_n = 1'b0;
          done_n = !chain;
          valid_n = rd && !chain;
          rdata_n = rd ? shreg : rdata;
        end
        // the chained read-data frame restarts here exactly as if freshly accepted
        if (cnt == CW'(GAP_CYCLES)) begin
          cnt_n = '0;
          sreg_n = chain ? {2'b11, 8'h00} : sreg;
          rd_n = chain ? 1'b1 : rd;
          chain_n = 1'b0;
          ready_n = !chain;
          state_n = chain ? LEAD : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sreg <= '0;
      shreg <= '0;
      rdata <= '0;
      rd <= 1'b0;
      chain <= 1'b0;
      ss_n <= 1'b1;
      mosi <= 1'b0;
      ready <= 1'b1;
      done <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sreg <= sreg_n;
      shreg <= shreg_n;
      rdata <= rdata_n;
      rd <= rd_n;
      chain <= chain_n;
      ss_n <= ss_n_n;
      mosi <= mosi_n;
      ready <= ready_n;
      done <= done_n;
      valid <= valid_n;
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master against a behavioural SPI slave/RAM model
module tb_spi_master;
  localparam int GAP = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_master_if bus();
  spi_master #(.TURN_CYCLES(2), .GAP_CYCLES(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int falls = 0;
  int dones = 0;
  int n = 0;
  logic prev_ss = 1'b1;
  logic [9:0] rx = '0;
  logic [7:0] mem [256];
  logic [255:0] wr_ok = '0;
  logic [7:0] addr = '0;
  logic [7:0] raddr = '0;
  logic [7:0] resp = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (prev_ss && !bus.SS_n) falls++;
    if (bus.done) dones++;
    prev_ss = bus.SS_n;
  end
  // slave model: frame bits follow the lead cycle; response starts after two turnaround cycles
  always @(posedge clk) begin
    #1;
    if (bus.SS_n) n = 0;
    else begin
      n++;
      if (n >= 2 && n <= 11) rx = {rx[8:0], bus.MOSI};
      if (n == 11)
        case (rx[9:8])
          2'b00: addr = rx[7:0];
          2'b01: begin mem[addr] = rx[7:0]; wr_ok[addr] = 1'b1; end
          2'b10: raddr = rx[7:0];
          default: resp = wr_ok[raddr] ? mem[raddr] : raddr ^ 8'hC3;
        endcase
    end
    bus.MISO = (n >= 13 && n <= 20) ? resp[3'(20 - n)] : ((n == 11 || n == 12) ? 1'bx : 1'b0);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  task automatic go(input logic [1:0] c, input logic [7:0] w, output int k);
    for (int i = 0; i < 50 && !bus.ready; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd = c;
    bus.wdata = w;
    @(posedge clk); #1;
    k = cyc;
    bus.start = 1'b0;
    check("accept_ready", 32'(bus.ready), 0);
  endtask
  task automatic run(input logic [1:0] c, input logic [7:0] w, output int lat, output logic v);
    int k;
    lat = -1;
    v = 1'b0;
    go(c, w, k);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = cyc - k;
        v = bus.rdata_valid;
        break;
      end
    end
  endtask
  initial begin
    int k, lat, d, d2, f, f0, d0;
    logic v;
    logic [10:0] seq;
    bus.start = 1'b0;
    bus.cmd = 2'b00;
    bus.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_ssn", 32'(bus.SS_n), 1);
    check("rst_mosi", 32'(bus.MOSI), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_valid", 32'(bus.rdata_valid), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    rst = 1'b0;
    go(2'b00, 8'h5A, k);
    seq = 11'b000_0101_1010;
    for (int i = 10; i >= 0; i--) begin
      @(posedge clk); #1;
      check("wr_ssn_low", 32'(bus.SS_n), 0);
      check("wr_mosi", 32'(bus.MOSI), 32'(seq[i]));
    end
    @(posedge clk); #1;
    check("wr_done", 32'(bus.done), 1);
    check("wr_ssn_high", 32'(bus.SS_n), 1);
    check("wr_mosi_idle", 32'(bus.MOSI), 0);
    check("wr_valid", 32'(bus.rdata_valid), 0);
    check("wr_ready_gap", 32'(bus.ready), 0);
    @(posedge clk); #1;
    check("wr_ready_back", 32'(bus.ready), 1);
    check("wr_done_pulse", 32'(bus.done), 0);
    go(2'b00, 8'h3C, k);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ssn", 32'(bus.SS_n), 1);
    check("abort_mosi", 32'(bus.MOSI), 0);
    check("abort_ready", 32'(bus.ready), 1);
    check("abort_done", 32'(bus.done), 0);
    check("abort_rdata", 32'(bus.rdata), 0);
    d0 = dones;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 32'(dones - d0), 0);
    run(2'b11, 8'h00, lat, v);
    check("rd_lat", 32'(lat), 22);
    check("rd_valid", 32'(v), 1);
    check("rd_rdata", 32'(bus.rdata), 32'h C3);
    check("rd_ssn_high", 32'(bus.SS_n), 1);
    @(posedge clk); #1;
    check("rd_valid_pulse", 32'(bus.rdata_valid), 0);
    run(2'b00, 8'h10, lat, v);
    check("e2e_wa_lat", 32'(lat), 12);
    run(2'b01, 8'hA5, lat, v);
    check("e2e_wd_lat", 32'(lat), 12);
    check("e2e_wd_rdata_kept", 32'(bus.rdata), 32'h C3);
`ifdef SPI_MASTER_AUTO_RD_EN
    @(negedge clk);
    f0 = falls;
    d0 = dones;
    run(2'b10, 8'h10, lat, v);
    check("auto_lat", 32'(lat), 35);
    check("auto_valid", 32'(v), 1);
    check("auto_rdata", 32'(bus.rdata), 32'h A5);
    @(negedge clk);
    check("auto_frames", 32'(falls - f0), 2);
    check("auto_dones", 32'(dones - d0), 1);
`else
    run(2'b10, 8'h10, lat, v);
    check("e2e_ra_lat", 32'(lat), 12);
    check("e2e_ra_valid", 32'(v), 0);
    check("e2e_ra_rdata_kept", 32'(bus.rdata), 32'h C3);
    run(2'b11, 8'h00, lat, v);
    check("e2e_rd_lat", 32'(lat), 22);
    check("e2e_rd_valid", 32'(v), 1);
    check("e2e_rd_rdata", 32'(bus.rdata), 32'h A5);
`endif
    for (int i = 0; i < 50 && !bus.ready; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd = 2'b00;
    bus.wdata = 8'hFF;
    @(posedge clk); #1;
    k = cyc;
    d = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin d = cyc; break; end
    end
    check("b2b_lat1", 32'(d - k), 12);
    f = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus.SS_n) begin f = cyc; break; end
    end
    check("b2b_gap", 32'(f - d), 32'(GAP + 2));
    bus.start = 1'b0;
    d2 = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin d2 = cyc; break; end
    end
    check("b2b_lat2", 32'(d2 - (f - 1)), 12);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_idle_ready", 32'(bus.ready), 1);
    check("b2b_idle_ssn", 32'(bus.SS_n), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
